mac_accumulate_stage: RTL and testbench

- Downstream of the Dadda partial-product reduction stage.
- Consumes its two 17-bit carry-save rows (sum row, carry row) and resolves them with a final carry-propagate add into a registered 16-bit accumulator.
- The accumulator is fed back as the 16-bit addend M of the reduction stage, so each accepted row pair equals a*b + acc.
- Sequences bursts of BURST-length multiply-accumulates and presents the result with a valid/ready handshake.

---
 rtl/mac_accumulate_stage_if.sv | 30 +++
 rtl/mac_accumulate_stage.sv | 140 ++++++++++++++
 tb/tb_mac_accumulate_stage.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mac_accumulate_stage_if.sv
// Row-pair and result streams of the MAC accumulate stage.
//   row_sum / row_carry : carry-save rows from the reduction stage
//   in_valid / in_ready : row-pair handshake (master drives valid)
//   result / result_ovf : burst result and sticky overflow
//   out_valid / out_ready : result handshake (master drives ready)
// master: the environment (reduction stage + result consumer)
// slave : the accumulate stage itself
interface mac_accumulate_stage_if #(
  parameter int ROW_W = 17,
  parameter int ACC_W = 16
);
  logic [ROW_W-1:0] row_sum;
  logic [ROW_W-1:0] row_carry;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] result;
  logic             result_ovf;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output row_sum, row_carry, in_valid, out_ready,
    input  in_ready, result, result_ovf, out_valid
  );

  modport slave (
    input  row_sum, row_carry, in_valid, out_ready,
    output in_ready, result, result_ovf, out_valid
  );
endinterface

// File: rtl/mac_accumulate_stage.sv
// Final carry-propagate add and burst accumulator behind a Dadda reduction
// stage. Each accepted carry-save row pair already contains a*b + acc_fb, so
// resolving it and registering the low ACC_W bits closes the MAC loop.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : pulse in IDLE that clears the accumulator and begins a burst
//   burst_len   : number of row pairs in the burst, sampled with start
//   busy        : high while a burst is running or its result is pending
//   acc_fb      : registered accumulator, fed back as the reduction addend
//   beat_cnt    : row pairs accepted so far in the current burst
//   bus         : row-pair input and result output streams
module mac_accumulate_stage #(
  parameter int ROW_W = 17,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_W-1:0]      burst_len,
  output logic                  busy,
  output logic [ACC_W-1:0]      acc_fb,
  output logic [CNT_W-1:0]      beat_cnt,
  mac_accumulate_stage_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic             result_ovf_q, result_ovf_d;
  logic             out_valid_q, out_valid_d;

  logic [ROW_W:0]   sum_full;
  logic             sum_ovf;
  logic             xfer;

  // Full-width resolve of the carry-save pair; anything above ACC_W bits is
  // lost to the wrap and only remembered through the sticky overflow.
  assign sum_full = {1'b0, bus.row_sum} + {1'b0, bus.row_carry};
  assign sum_ovf  = |sum_full[ROW_W:ACC_W];

  assign bus.in_ready   = (state_q == ACCUM);
  assign xfer           = bus.in_valid && bus.in_ready;
  assign busy           = (state_q != IDLE);
  assign acc_fb         = acc_q;
  assign beat_cnt       = cnt_q;
  assign bus.result     = result_q;
  assign bus.result_ovf = result_ovf_q;
  assign bus.out_valid  = out_valid_q;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    ovf_d        = ovf_q;
    result_d     = result_q;
    result_ovf_d = result_ovf_q;
    out_valid_d  = out_valid_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
          len_d = burst_len;
          // An empty burst still produces a (zero) result to hand off.
          if (burst_len == '0) begin
            result_d     = '0;
            result_ovf_d = 1'b0;
            out_valid_d  = 1'b1;
            state_d      = DONE;
          end else begin
            state_d = ACCUM;
          end
        end
      end

      ACCUM: begin
        if (xfer) begin
          acc_d = sum_full[ACC_W-1:0];
          ovf_d = ovf_q | sum_ovf;
          cnt_d = cnt_q + 1'b1;
          if ((cnt_q + 1'b1) == len_q) begin
            result_d     = sum_full[ACC_W-1:0];
            result_ovf_d = ovf_q | sum_ovf;
            out_valid_d  = 1'b1;
            state_d      = DONE;
          end
        end
      end

      DONE: begin
        // start is deliberately not looked at here, even on the hand-off cycle.
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      len_q        <= '0;
      ovf_q        <= 1'b0;
      result_q     <= '0;
      result_ovf_q <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      ovf_q        <= ovf_d;
      result_q     <= result_d;
      result_ovf_q <= result_ovf_d;
      out_valid_q  <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_mac_accumulate_stage.sv
// Self-checking bench for mac_accumulate_stage: directed bursts with literal
// expectations plus a burst-level reference model compared every cycle.
module tb_mac_accumulate_stage;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  burst_len;
  logic        busy;
  logic [15:0] acc_fb;
  logic [7:0]  beat_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  mac_accumulate_stage_if #(.ROW_W(17), .ACC_W(16)) bus ();

  mac_accumulate_stage #(.ROW_W(17), .ACC_W(16), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .burst_len (burst_len),
    .busy      (busy),
    .acc_fb    (acc_fb),
    .beat_cnt  (beat_cnt),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 0 = waiting for start, 1 = collecting row pairs,
  // 2 = result pending. Sums are plain integers; wrap and overflow come
  // from comparing against 2**16.
  int m_phase, m_acc, m_cnt, m_len, m_res, m_ovf, m_sticky;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase  <= 0;
      m_acc    <= 0;
      m_cnt    <= 0;
      m_len    <= 0;
      m_res    <= 0;
      m_ovf    <= 0;
      m_sticky <= 0;
    end else begin
      if (m_phase == 0) begin
        if (start) begin
          m_acc    <= 0;
          m_cnt    <= 0;
          m_sticky <= 0;
          m_len    <= int'(burst_len);
          if (burst_len == 8'd0) begin
            m_res   <= 0;
            m_ovf   <= 0;
            m_phase <= 2;
          end else begin
            m_phase <= 1;
          end
        end
      end else if (m_phase == 1) begin
        if (bus.in_valid) begin
          int s;
          int big;
          s   = int'(bus.row_sum) + int'(bus.row_carry);
          big = (s >= 65536) ? 1 : 0;
          m_acc    <= s % 65536;
          m_cnt    <= m_cnt + 1;
          m_sticky <= m_sticky | big;
          if (m_cnt + 1 == m_len) begin
            m_res   <= s % 65536;
            m_ovf   <= m_sticky | big;
            m_phase <= 2;
          end
        end
      end else begin
        if (bus.out_ready) m_phase <= 0;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_assert++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Cycle-by-cycle comparison against the model while out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("model acc_fb",    int'(acc_fb),        m_acc);
      checkOutput("model beat_cnt",  int'(beat_cnt),      m_cnt);
      checkOutput("model busy",      int'(busy),          (m_phase != 0) ? 1 : 0);
      checkOutput("model in_ready",  int'(bus.in_ready),  (m_phase == 1) ? 1 : 0);
      checkOutput("model out_valid", int'(bus.out_valid), (m_phase == 2) ? 1 : 0);
      if (m_phase == 2) begin
        checkOutput("model result",     int'(bus.result),     m_res);
        checkOutput("model result_ovf", int'(bus.result_ovf), m_ovf);
      end
    end
  end

  // Drive one cycle of inputs (called just after a falling edge) and return
  // just after the next falling edge, once the rising edge has taken effect.
  task automatic applyStimulus(input logic st, input logic [7:0] len, input logic v,
                               input logic [16:0] s, input logic [16:0] c,
                               input logic ordy);
    start         = st;
    burst_len     = len;
    bus.in_valid  = v;
    bus.row_sum   = s;
    bus.row_carry = c;
    bus.out_ready = ordy;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Emulates the reduction stage: carry-save form of a*b + acc_fb.
  task automatic reduceBeat(input int a, input int b);
    logic [16:0] p;
    logic [16:0] m;
    p = 17'(a * b);
    m = {1'b0, acc_fb};
    applyStimulus(1'b0, 8'd0, 1'b1, p ^ m, (p & m) << 1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] bench timed out");
  end

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    burst_len     = 8'd0;
    bus.in_valid  = 1'b0;
    bus.row_sum   = '0;
    bus.row_carry = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset acc_fb",    int'(acc_fb),        0);
    checkOutput("reset out_valid", int'(bus.out_valid), 0);
    checkOutput("reset busy",      int'(busy),          0);
    checkOutput("reset in_ready",  int'(bus.in_ready),  0);
    rst_n = 1'b1;

    $display("[TB] basic 3-beat burst");
    applyStimulus(1'b1, 8'd3, 1'b0, 17'h0, 17'h0, 1'b0);
    checkOutput("basic in_ready", int'(bus.in_ready), 1);
    applyStimulus(1'b0, 8'd0, 1'b1, 17'h00005, 17'h00003, 1'b0);
    checkOutput("basic acc1", int'(acc_fb), 'h0008);
    applyStimulus(1'b0, 8'd0, 1'b1, 17'h00010, 17'h00008, 1'b0);
    checkOutput("basic acc2", int'(acc_fb), 'h0018);
    applyStimulus(1'b0, 8'd0, 1'b1, 17'h00100, 17'h00000, 1'b0);
    checkOutput("basic acc3",      int'(acc_fb),         'h0100);
    checkOutput("basic result",    int'(bus.result),     'h0100);
    checkOutput("basic ovf",       int'(bus.result_ovf), 0);
    checkOutput("basic out_valid", int'(bus.out_valid),  1);
    applyStimulus(1'b0, 8'd0, 1'b0, 17'h0, 17'h0, 1'b1);
    checkOutput("basic handoff", int'(bus.out_valid), 0);

    $display("[TB] overflow and wrap");
    applyStimulus(1'b1, 8'd1, 1'b0, 17'h0, 17'h0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 17'h1FFFF, 17'h00002, 1'b0);
    checkOutput("ovf result", int'(bus.result),     'h0001);
    checkOutput("ovf flag",   int'(bus.result_ovf), 1);
    applyStimulus(1'b0, 8'd0, 1'b0, 17'h0, 17'h0, 1'b1);

    $display("[TB] stall and backpressure");
    applyStimulus(1'b1, 8'd2, 1'b0, 17'h0, 17'h0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 17'h00020, 17'h00001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'd0, 1'b0, 17'h1FFFF, 17'h1FFFF, 1'b0);
      checkOutput("stall beat_cnt", int'(beat_cnt), 1);
      checkOutput("stall acc_fb",   int'(acc_fb),   'h0021);
    end
    applyStimulus(1'b0, 8'd0, 1'b1, 17'h00040, 17'h00000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus((i % 2 == 0) ? 1'b1 : 1'b0, 8'd5, 1'b1, 17'h00007, 17'h0, 1'b0);
      checkOutput("backpressure out_valid", int'(bus.out_valid), 1);
      checkOutput("backpressure result",    int'(bus.result),    'h0040);
    end
    applyStimulus(1'b1, 8'd5, 1'b0, 17'h0, 17'h0, 1'b1);
    checkOutput("handoff start ignored", int'(busy), 0);

    $display("[TB] zero-length burst");
    applyStimulus(1'b1, 8'd0, 1'b1, 17'h00055, 17'h00055, 1'b0);
    checkOutput("zero out_valid", int'(bus.out_valid),  1);
    checkOutput("zero result",    int'(bus.result),     0);
    checkOutput("zero ovf",       int'(bus.result_ovf), 0);
    checkOutput("zero in_ready",  int'(bus.in_ready),   0);
    applyStimulus(1'b0, 8'd0, 1'b0, 17'h0, 17'h0, 1'b1);

    $display("[TB] reset mid-burst");
    applyStimulus(1'b1, 8'd3, 1'b0, 17'h0, 17'h0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 17'h01234, 17'h00000, 1'b0);
    checkOutput("midreset pre acc_fb", int'(acc_fb), 'h1234);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset acc_fb",    int'(acc_fb),        0);
    checkOutput("midreset out_valid", int'(bus.out_valid), 0);
    checkOutput("midreset in_ready",  int'(bus.in_ready),  0);
    checkOutput("midreset busy",      int'(busy),          0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] closed loop with reduction stage");
    applyStimulus(1'b1, 8'd4, 1'b0, 17'h0, 17'h0, 1'b0);
    reduceBeat(3, 5);
    reduceBeat(7, 9);
    reduceBeat(255, 255);
    reduceBeat(2, 2);
    checkOutput("loop result", int'(bus.result),     'hFE53);
    checkOutput("loop ovf",    int'(bus.result_ovf), 0);
    applyStimulus(1'b0, 8'd0, 1'b0, 17'h0, 17'h0, 1'b1);
    applyStimulus(1'b1, 8'd1, 1'b0, 17'h0, 17'h0, 1'b0);
    reduceBeat(1, 1);
    checkOutput("loop2 result", int'(bus.result), 'h0001);
    applyStimulus(1'b0, 8'd0, 1'b0, 17'h0, 17'h0, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b0, 17'h0, 17'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
